// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes header words from an SPI slave into register
// writes, register/status reads and accelerator start requests.
module spi_cmd_ctrl #(
  parameter int DATA_SIZE = 16,
  parameter int NREG      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      rx_valid,
  input  logic [DATA_SIZE-1:0]      rx_data,
  output logic                      tx_valid,
  output logic [DATA_SIZE-1:0]      tx_data,
  input  logic                      tx_ready,
  output logic [NREG*DATA_SIZE-1:0] cfg_regs,
  output logic                      acc_start,
  input  logic                      acc_busy,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  localparam logic [3:0]           ADDR_STATUS = 4'd8;
  localparam logic [3:0]           ADDR_CLRERR = 4'd15;
  localparam logic [DATA_SIZE-1:0] DEAD_WORD   = DATA_SIZE'(16'hDEAD);

  state_t               state_q, state_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 word_vld_q, word_vld_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic [3:0]           wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0] cfg_q [NREG];
  logic [DATA_SIZE-1:0] cfg_d [NREG];
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 acc_start_q, acc_start_d;
  logic                 err_q, err_d;

  logic                 nw_hit;
  logic                 consume;
  logic [1:0]           hdr_op;
  logic [3:0]           hdr_addr;
  logic                 addr_in_range;
  logic [DATA_SIZE-1:0] status_word;
  logic [DATA_SIZE-1:0] rd_val;

  // A word is only taken on a fresh rx_valid rising edge inside an open frame,
  // so a level held high for many cycles yields a single header.
  assign nw_hit        = rx_valid & ~rx_valid_q & ~cs;
  assign hdr_op        = word_q[DATA_SIZE-1 -: 2];
  assign hdr_addr      = word_q[3:0];
  assign addr_in_range = (32'(hdr_addr) < NREG);

  always_comb begin
    status_word                = '0;
    status_word[DATA_SIZE-1]   = acc_busy;
    status_word[DATA_SIZE-2]   = err_q;
  end

  always_comb begin
    rd_val = DEAD_WORD;
    if (hdr_addr == ADDR_STATUS) begin
      rd_val = status_word;
    end
    for (int i = 0; i < NREG; i++) begin
      if (hdr_addr == 4'(i)) begin
        rd_val = cfg_q[i];
      end
    end
  end

  // The captured word stays pending while a response is being shifted out, so a
  // header arriving in RESP is decoded once the FSM is back in IDLE.
  always_comb begin
    state_d     = state_q;
    rx_valid_d  = rx_valid;
    word_vld_d  = word_vld_q;
    word_d      = word_q;
    wr_addr_d   = wr_addr_q;
    cfg_d       = cfg_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    acc_start_d = 1'b0;
    err_d       = err_q;
    consume     = 1'b0;

    if (cs) begin
      state_d    = IDLE;
      word_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (word_vld_q) begin
            consume = 1'b1;
            unique case (hdr_op)
              OP_WRITE: begin
                if (hdr_addr == ADDR_CLRERR) begin
                  err_d = 1'b0;
                end else if (addr_in_range) begin
                  state_d   = WDATA;
                  wr_addr_d = hdr_addr;
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_READ: begin
                tx_data_d  = rd_val;
                tx_valid_d = ~tx_valid_q;
                state_d    = RESP;
                if (!addr_in_range && (hdr_addr != ADDR_STATUS)) begin
                  err_d = 1'b1;
                end
              end
              OP_START: begin
                if (acc_busy) begin
                  err_d = 1'b1;
                end else begin
                  acc_start_d = ~acc_start_q;
                end
              end
              OP_NOP: begin
              end
              default: begin
              end
            endcase
          end
        end
        WDATA: begin
          if (word_vld_q) begin
            consume = 1'b1;
            for (int i = 0; i < NREG; i++) begin
              if (wr_addr_q == 4'(i)) begin
                cfg_d[i] = word_q;
              end
            end
            state_d = IDLE;
          end
        end
        RESP: begin
          if (tx_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (nw_hit) begin
        word_vld_d = 1'b1;
        word_d     = rx_data;
      end else if (consume) begin
        word_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_valid_q  <= 1'b0;
      word_vld_q  <= 1'b0;
      word_q      <= '0;
      wr_addr_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      acc_start_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      word_vld_q  <= word_vld_d;
      word_q      <= word_d;
      wr_addr_q   <= wr_addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      acc_start_q <= acc_start_d;
      err_q       <= err_d;
      for (int i = 0; i < NREG; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg_out
    assign cfg_regs[g*DATA_SIZE +: DATA_SIZE] = cfg_q[g];
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign acc_start = acc_start_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl: drives SPI words as rx_valid
// edges and compares outputs against hand-computed values.
module tb_spi_cmd_ctrl;

  localparam int DW = 16;
  localparam int NR = 8;

  logic             clk;
  logic             rst_n;
  logic             cs;
  logic             rx_valid;
  logic [DW-1:0]    rx_data;
  logic             tx_valid;
  logic [DW-1:0]    tx_data;
  logic             tx_ready;
  logic [NR*DW-1:0] cfg_regs;
  logic             acc_start;
  logic             acc_busy;
  logic             err;

  int num_checks = 0;
  int num_fail   = 0;
  int tx_cnt     = 0;
  int acc_cnt    = 0;
  int consec_cnt = 0;
  logic tx_prev  = 1'b0;
  logic acc_prev = 1'b0;
  int tx_base;
  int acc_base;

  spi_cmd_ctrl #(.DATA_SIZE(DW), .NREG(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .cfg_regs  (cfg_regs),
    .acc_start (acc_start),
    .acc_busy  (acc_busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample the registered outputs at every rising edge.
  always @(posedge clk) begin
    if (tx_valid) tx_cnt++;
    if (acc_start) acc_cnt++;
    if ((tx_valid && tx_prev) || (acc_start && acc_prev)) consec_cnt++;
    tx_prev  = tx_valid;
    acc_prev = acc_start;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SPI word: rx_valid rises, is seen on the next edge, decoded on the one after.
  task automatic applyStimulus(input logic [DW-1:0] word);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = word;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic releaseTx();
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] reg_of(input int idx);
    return cfg_regs[idx*DW +: DW];
  endfunction

  initial begin
    rst_n    = 1'b0;
    cs       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    acc_busy = 1'b0;
    idleCycles(3);
    checkOutput("rst_cfg", cfg_regs, '0);
    checkOutput("rst_tx_data", tx_data, 16'h0000);
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_acc_start", acc_start, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst_n = 1'b1;
    cs    = 1'b0;
    idleCycles(2);

    // write then read back register 3
    applyStimulus(16'h4003);
    applyStimulus(16'h1234);
    checkOutput("wr_reg3", reg_of(3), 16'h1234);
    tx_base = tx_cnt;
    applyStimulus(16'h8003);
    checkOutput("rd_tx_valid", tx_valid, 1'b1);
    checkOutput("rd_tx_data", tx_data, 16'h1234);
    idleCycles(4);
    checkOutput("rd_tx_valid_drop", tx_valid, 1'b0);
    checkOutput("rd_tx_hold", tx_data, 16'h1234);
    checkOutput("rd_one_pulse", tx_cnt - tx_base, 1);
    releaseTx();

    // start while idle and while busy, then status read
    acc_base = acc_cnt;
    applyStimulus(16'hC000);
    checkOutput("start_pulse", acc_start, 1'b1);
    idleCycles(2);
    checkOutput("start_count", acc_cnt - acc_base, 1);
    checkOutput("start_err", err, 1'b0);
    acc_busy = 1'b1;
    acc_base = acc_cnt;
    applyStimulus(16'hC000);
    idleCycles(2);
    checkOutput("busy_no_pulse", acc_cnt - acc_base, 0);
    checkOutput("busy_err", err, 1'b1);
    applyStimulus(16'h8008);
    checkOutput("status_word", tx_data, 16'hC000);
    releaseTx();
    acc_busy = 1'b0;
    applyStimulus(16'h400F);
    checkOutput("clr_err", err, 1'b0);

    // abort a pending write with cs
    applyStimulus(16'h4002);
    @(negedge clk);
    cs = 1'b1;
    idleCycles(2);
    cs = 1'b0;
    applyStimulus(16'h8002);
    checkOutput("abort_tx_valid", tx_valid, 1'b1);
    checkOutput("abort_tx_data", tx_data, 16'h0000);
    checkOutput("abort_reg2", reg_of(2), 16'h0000);
    releaseTx();

    // out-of-range write, then clear; clear must not open a data phase
    applyStimulus(16'h400A);
    checkOutput("bad_wr_err", err, 1'b1);
    checkOutput("bad_wr_cfg", cfg_regs, 128'h1234 << (3*DW));
    applyStimulus(16'h400F);
    checkOutput("bad_wr_clr", err, 1'b0);
    applyStimulus(16'h8003);
    checkOutput("clr_no_wdata", tx_data, 16'h1234);
    checkOutput("clr_no_wdata_v", tx_valid, 1'b1);
    releaseTx();

    // read of an unmapped address
    applyStimulus(16'h800C);
    checkOutput("bad_rd_data", tx_data, 16'hDEAD);
    checkOutput("bad_rd_err", err, 1'b1);
    releaseTx();
    applyStimulus(16'h400F);
    checkOutput("bad_rd_clr", err, 1'b0);

    // rx_valid held high for 50 cycles counts once
    acc_base = acc_cnt;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 16'hC000;
    idleCycles(50);
    rx_valid = 1'b0;
    idleCycles(3);
    checkOutput("level_hold", acc_cnt - acc_base, 1);

    // header arriving during RESP is kept and decoded afterwards
    tx_base = tx_cnt;
    applyStimulus(16'h8003);
    applyStimulus(16'h4004);
    idleCycles(2);
    releaseTx();
    idleCycles(2);
    applyStimulus(16'h00AB);
    checkOutput("resp_latched_wr", reg_of(4), 16'h00AB);
    idleCycles(2);
    checkOutput("resp_one_pulse", tx_cnt - tx_base, 1);

    // word detected but cs rises before it is decoded: dropped
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 16'h4006;
    @(negedge clk);
    rx_valid = 1'b0;
    cs       = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    idleCycles(1);
    applyStimulus(16'h0077);
    checkOutput("cs_drop_reg6", reg_of(6), 16'h0000);

    // reset in the middle of a data phase
    applyStimulus(16'h4001);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h5555);
    applyStimulus(16'h0099);
    checkOutput("rst_mid_reg5", reg_of(5), 16'h0099);
    checkOutput("rst_mid_reg1", reg_of(1), 16'h0000);
    checkOutput("rst_mid_cfg", cfg_regs, 128'h0099 << (5*DW));

    idleCycles(2);
    checkOutput("no_back_to_back", consec_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
